mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
- Sequencer for a chain of mac_col columns.
- Fetches K vectors, then Q vectors, from a single-port 64-bit operand SRAM and drives the chain head's q_in/i_inst.
- Order of operation: load phase (inst 01, one K vector per column), a settle gap, then execute phase (inst 10, one Q vector per cycle).
- Counts fifo_wr pulses from the last column and raises done when all results are out.

Parameters:
- col, 3, number of mac_col instances in the chain (1..16)
- bw, 8, element width
- pr, 8, elements per vector; q bus width = bw*pr
- addr_w, 6, operand SRAM address width
- cnt_w, 8, width of the Q-count field
- drain_max, 255, watchdog limit in DRAIN (cycles without completion)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- k_base  in  addr_w  SRAM address of K vector 0; K vectors are contiguous
- q_base  in  addr_w  SRAM address of Q vector 0; Q vectors are contiguous
- num_q  in  cnt_w  number of Q vectors to stream (0 is legal)
- mem_cen  out  1  SRAM read enable, active-high
- mem_addr  out  addr_w  SRAM address
- mem_rdata  in  bw*pr  SRAM data, valid exactly 1 cycle after mem_cen
- q_out  out  bw*pr  to q_in of column 0
- inst_out  out  2  to i_inst of column 0: 00 idle, 01 load K, 10 execute
- res_wr  in  1  fifo_wr of the last column
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- timeout  out  1  one-cycle pulse if the DRAIN watchdog expires

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- num_q, k_base and q_base are latched on an accepted start; later changes to these inputs are ignored.
- Read pipeline, used in both load and execute phases:
  - Cycle t: mem_cen=1 and mem_addr registered.
  - Cycle t+1: mem_rdata valid.
  - Cycle t+2: q_out = registered rdata, inst_out = matching registered instruction.
  - Fixed issue-to-chain latency is 2 cycles. inst_out is 00 in any cycle without an aligned read.
  - q_out holds its last value while inst_out is 00.
- IDLE:
  - start=1 → LOAD, k counter cleared.
  - start while busy is ignored.
- LOAD:
  - Issues col reads at k_base+0 .. k_base+col-1 on consecutive cycles, each tagged 01.
  - Goes to GAP after the last issue.
- GAP:
  - Waits col+2 cycles so the last 01 reaches and clears column col-1 and the pipeline has emptied.
  - Then → EXEC, or straight to DONE_ST if num_q==0.
- EXEC:
  - Issues num_q reads at q_base+0 .. q_base+num_q-1 back-to-back, each tagged 10.
  - Goes to DRAIN after the last issue.
  - Address arithmetic wraps modulo 2^addr_w.
- DRAIN:
  - Result counter increments on each res_wr. Counting is active from EXEC entry, so pulses that arrive during EXEC are also counted.
  - When count == num_q → DONE_ST.
  - Watchdog counts DRAIN cycles with no completion. On reaching drain_max: timeout=1 for one cycle → IDLE, with no done pulse.
- DONE_ST: done=1 for one cycle → IDLE.
- Excess res_wr pulses (count already == num_q) are ignored. res_wr in IDLE is ignored.
- Reset mid-operation: immediately returns to IDLE. mem_cen and inst_out are 0 in the following cycle, and no done or timeout pulse is generated.

Decomposition:
- Package mac_ctrl_pkg:
  - inst encodings INST_IDLE=2'b00, INST_LOAD=2'b01, INST_EXEC=2'b10
  - state enum IDLE, LOAD, GAP, EXEC, DRAIN, DONE_ST
- One sub-module, mac_rd_pipe: 2-stage alignment of rdata and instruction tag (cen/tag in → q_out/inst_out).

Test Plan:
- col=3, k_base=0, q_base=8, num_q=3, SRAM model returns addr-derived data:
  - mem_addr sequence 0,1,2 (cen), then a 5-cycle gap, then 8,9,10.
  - inst_out shows 01×3 starting 2 cycles after the first cen, and 10×3 starting 2 cycles after address 8.
- Same run with a 3-column mac_col chain plus a golden dot-product model: the last column gives 3 res_wr pulses → done exactly 1 cycle after the 3rd pulse; the outputs match the golden Q·K values.
- num_q=0: the load phase runs, then done asserts immediately after GAP; no 10 instruction is ever issued.
- q_base=62, num_q=4, addr_w=6 → addresses 62,63,0,1.
- No res_wr in DRAIN → timeout pulse after 255 cycles, done stays 0, busy drops.
- reset asserted mid-EXEC → next cycle mem_cen=0, inst_out=00, busy=0; a fresh start then completes normally. A start while busy is ignored.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared encodings for the MAC array sequencer.
package mac_ctrl_pkg;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    EXEC,
    DRAIN,
    DONE_ST
  } state_t;

endpackage

// File: rtl/mac_rd_pipe.sv
// Two-stage alignment of SRAM read data with its instruction tag.
// Stage 1 carries the tag alongside the SRAM access; stage 2 captures
// rdata together with the tag so both reach the chain head in the same cycle.
module mac_rd_pipe
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned dw = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cen,
  input  logic [1:0]    tag,
  input  logic [dw-1:0] rdata,
  output logic [dw-1:0] q_out,
  output logic [1:0]    inst_out
);

  logic       v1;
  logic [1:0] tag1;

  // Stage 1: follow the read request into the data-valid cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1   <= 1'b0;
      tag1 <= INST_IDLE;
    end else begin
      v1   <= cen;
      tag1 <= tag;
    end
  end

  // Stage 2: present data and tag; data holds while no read is aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_out    <= '0;
      inst_out <= INST_IDLE;
    end else if (v1) begin
      q_out    <= rdata;
      inst_out <= tag1;
    end else begin
      inst_out <= INST_IDLE;
    end
  end

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for a mac_col chain: loads one K vector per column, waits for
// the chain to settle, streams Q vectors, then counts results to completion.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned col       = 3,
  parameter int unsigned bw        = 8,
  parameter int unsigned pr        = 8,
  parameter int unsigned addr_w    = 6,
  parameter int unsigned cnt_w     = 8,
  parameter int unsigned drain_max = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w-1:0]   k_base,
  input  logic [addr_w-1:0]   q_base,
  input  logic [cnt_w-1:0]    num_q,
  output logic                mem_cen,
  output logic [addr_w-1:0]   mem_addr,
  input  logic [bw*pr-1:0]    mem_rdata,
  output logic [bw*pr-1:0]    q_out,
  output logic [1:0]          inst_out,
  input  logic                res_wr,
  output logic                busy,
  output logic                done,
  output logic                timeout
);

  localparam int unsigned DW   = bw * pr;
  // One counter serves both LOAD (0..col-1) and GAP (0..col+1).
  localparam int unsigned PC_W = $clog2(col + 2);
  localparam int unsigned WD_W = (drain_max < 2) ? 1 : $clog2(drain_max + 1);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [cnt_w-1:0]  q_cnt, q_cnt_nxt;
  logic [cnt_w-1:0]  res_cnt, res_cnt_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  logic [cnt_w-1:0]  num_q_r;
  logic [addr_w-1:0] k_base_r, q_base_r;
  logic [1:0]        tag_r;
  logic              issue;
  logic [addr_w-1:0] issue_addr;
  logic [1:0]        issue_tag;
  logic              to_fire;
  logic              accept;

  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE_ST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Result counter: active from EXEC entry, saturates at num_q so excess
  // pulses are dropped.
  always_comb begin
    res_cnt_nxt = res_cnt;
    if ((state == EXEC || state == DRAIN) && res_wr && (res_cnt != num_q_r))
      res_cnt_nxt = res_cnt + 1'b1;
  end

  // Next-state, read issue and counter updates.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    q_cnt_nxt  = q_cnt;
    wd_nxt     = wd_cnt;
    issue      = 1'b0;
    issue_addr = mem_addr;
    issue_tag  = INST_IDLE;
    to_fire    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          pc_nxt    = '0;
          q_cnt_nxt = '0;
          wd_nxt    = '0;
        end
      end
      LOAD: begin
        issue      = 1'b1;
        issue_addr = k_base_r + addr_w'(pc);
        issue_tag  = INST_LOAD;
        if (pc == PC_W'(col - 1)) begin
          state_nxt = GAP;
          pc_nxt    = '0;
        end else begin
          pc_nxt = pc + 1'b1;
        end
      end
      GAP: begin
        if (pc == PC_W'(col + 1)) begin
          pc_nxt    = '0;
          q_cnt_nxt = '0;
          state_nxt = (num_q_r == '0) ? DONE_ST : EXEC;
        end else begin
          pc_nxt = pc + 1'b1;
        end
      end
      EXEC: begin
        issue      = 1'b1;
        issue_addr = q_base_r + addr_w'(q_cnt);
        issue_tag  = INST_EXEC;
        if (q_cnt == num_q_r - 1'b1) begin
          state_nxt = DRAIN;
          wd_nxt    = '0;
        end else begin
          q_cnt_nxt = q_cnt + 1'b1;
        end
      end
      DRAIN: begin
        // Completion is judged on the updated count so done follows the
        // final res_wr by exactly one cycle.
        if (res_cnt_nxt == num_q_r) begin
          state_nxt = DONE_ST;
        end else if (wd_cnt == WD_W'(drain_max - 1)) begin
          state_nxt = IDLE;
          to_fire   = 1'b1;
        end else begin
          wd_nxt = wd_cnt + 1'b1;
        end
      end
      DONE_ST: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counters, latched job parameters and registered SRAM request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= '0;
      q_cnt    <= '0;
      res_cnt  <= '0;
      wd_cnt   <= '0;
      num_q_r  <= '0;
      k_base_r <= '0;
      q_base_r <= '0;
      mem_cen  <= 1'b0;
      mem_addr <= '0;
      tag_r    <= INST_IDLE;
      timeout  <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      q_cnt    <= q_cnt_nxt;
      wd_cnt   <= wd_nxt;
      res_cnt  <= accept ? '0 : res_cnt_nxt;
      if (accept) begin
        num_q_r  <= num_q;
        k_base_r <= k_base;
        q_base_r <= q_base;
      end
      mem_cen  <= issue;
      mem_addr <= issue_addr;
      tag_r    <= issue_tag;
      timeout  <= to_fire;
    end
  end

  mac_rd_pipe #(
    .dw(DW)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .cen     (mem_cen),
    .tag     (tag_r),
    .rdata   (mem_rdata),
    .q_out   (q_out),
    .inst_out(inst_out)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl (col=3, addr_w=6, 64-bit operands).
module tb_mac_array_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  k_base, q_base;
  logic [7:0]  num_q;
  logic        mem_cen;
  logic [5:0]  mem_addr;
  logic [63:0] mem_rdata;
  logic [63:0] q_out;
  logic [1:0]  inst_out;
  logic        res_wr;
  logic        busy, done, timeout;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  typedef struct {int cyc; logic [5:0] addr;} rd_exp_t;
  typedef struct {int cyc; logic [1:0] inst; logic [63:0] data;} in_exp_t;

  rd_exp_t rd_q[$];
  in_exp_t in_q[$];
  int      done_q[$];
  int      to_q[$];

  rd_exp_t rd_m;
  in_exp_t in_m;
  int      ev_m;

  mac_array_ctrl #(
    .col(3), .bw(8), .pr(8), .addr_w(6), .cnt_w(8), .drain_max(255)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .k_base(k_base), .q_base(q_base),
    .num_q(num_q), .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .q_out(q_out), .inst_out(inst_out), .res_wr(res_wr), .busy(busy),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input logic [5:0] a);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[j*8 +: 8] = {2'b00, a} ^ 8'(j * 37);
    return r;
  endfunction

  // SRAM model: data one cycle after the enable.
  always @(posedge clk) if (mem_cen) mem_rdata <= pat(mem_addr);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexp(input string nm);
    total++;
    bad++;
    $display("FAIL %s: unexpected event got 1 want 0 (cycle %0d)", nm, cyc);
  endtask

  // Monitor: pops and compares whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (mem_cen === 1'b1) begin
      if (rd_q.size() == 0) unexp("rd_issue");
      else begin
        rd_m = rd_q.pop_front();
        chk("rd_cyc", 64'(cyc), 64'(rd_m.cyc));
        chk("rd_addr", 64'(mem_addr), 64'(rd_m.addr));
      end
    end
    if (inst_out !== 2'b00) begin
      if (in_q.size() == 0) unexp("inst");
      else begin
        in_m = in_q.pop_front();
        chk("inst_cyc", 64'(cyc), 64'(in_m.cyc));
        chk("inst_val", 64'(inst_out), 64'(in_m.inst));
        chk("q_data", q_out, in_m.data);
      end
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) unexp("done");
      else begin
        ev_m = done_q.pop_front();
        chk("done_cyc", 64'(cyc), 64'(ev_m));
      end
    end
    if (timeout === 1'b1) begin
      if (to_q.size() == 0) unexp("timeout");
      else begin
        ev_m = to_q.pop_front();
        chk("timeout_cyc", 64'(cyc), 64'(ev_m));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Start issued in cycle s: LOAD occupies s+1..s+3, reads visible s+2..s+4,
  // chain sees 01 at s+4..s+6. GAP s+4..s+8, EXEC from s+9, Q reads from s+10,
  // chain sees 10 from s+12.
  task automatic push_load(input int s, input int kb);
    for (int i = 0; i < 3; i++) begin
      rd_q.push_back('{s + 2 + i, 6'(kb + i)});
      in_q.push_back('{s + 4 + i, 2'b01, pat(6'(kb + i))});
    end
  endtask

  task automatic push_exec(input int s, input int qb, input int n);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back('{s + 10 + i, 6'(qb + i)});
      in_q.push_back('{s + 12 + i, 2'b10, pat(6'(qb + i))});
    end
  endtask

  task automatic do_start(input int kb, input int qb, input int nq, output int s);
    s = cyc;
    k_base = 6'(kb);
    q_base = 6'(qb);
    num_q  = 8'(nq);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    // Inputs change after acceptance; the latched values must be used.
    k_base = 6'h2a;
    q_base = 6'h15;
    num_q  = 8'd9;
  endtask

  task automatic pulse_at(input int c);
    goto(c);
    res_wr = 1'b1;
    tick();
    res_wr = 1'b0;
  endtask

  task automatic leftovers(input string nm);
    chk({nm, "_rd_left"}, 64'(rd_q.size()), 64'd0);
    chk({nm, "_inst_left"}, 64'(in_q.size()), 64'd0);
    chk({nm, "_done_left"}, 64'(done_q.size()), 64'd0);
    chk({nm, "_to_left"}, 64'(to_q.size()), 64'd0);
  endtask

  initial begin
    int s;
    reset = 1'b1; start = 1'b0; res_wr = 1'b0;
    k_base = '0; q_base = '0; num_q = '0;
    repeat (3) tick();
    chk("rst_cen", 64'(mem_cen), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_q", q_out, 64'd0);
    chk("rst_inst", 64'(inst_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_to", 64'(timeout), 64'd0);
    reset = 1'b0;
    tick();

    // Basic run: k_base=0, q_base=8, num_q=3; done one cycle after 3rd res_wr.
    do_start(0, 8, 3, s);
    push_load(s, 0);
    push_exec(s, 8, 3);
    done_q.push_back(s + 19);
    pulse_at(s + 15);
    pulse_at(s + 17);
    pulse_at(s + 18);
    pulse_at(s + 19);      // excess, ignored
    pulse_at(s + 22);      // idle, ignored
    goto(s + 30);
    chk("q_hold", q_out, pat(6'd10));
    chk("basic_busy_end", 64'(busy), 64'd0);
    leftovers("basic");

    // num_q=0: load phase only, done right after GAP.
    do_start(20, 8, 0, s);
    push_load(s, 20);
    done_q.push_back(s + 9);
    goto(s + 8);
    chk("nq0_busy", 64'(busy), 64'd1);
    goto(s + 20);
    leftovers("nq0");

    // Address wrap 62,63,0,1; one result arrives during EXEC.
    do_start(5, 62, 4, s);
    push_load(s, 5);
    push_exec(s, 62, 4);
    done_q.push_back(s + 21);
    pulse_at(s + 11);
    pulse_at(s + 14);
    pulse_at(s + 16);
    pulse_at(s + 20);
    pulse_at(s + 25);      // idle, ignored
    goto(s + 32);
    leftovers("wrap");

    // Watchdog: DRAIN spans s+11..s+265, timeout pulse at s+266.
    do_start(0, 8, 2, s);
    push_load(s, 0);
    push_exec(s, 8, 2);
    to_q.push_back(s + 266);
    goto(s + 265);
    chk("wd_busy_pre", 64'(busy), 64'd1);
    goto(s + 266);
    chk("wd_busy_post", 64'(busy), 64'd0);
    goto(s + 275);
    leftovers("wd");

    // Start while busy is ignored; reset mid-EXEC aborts silently.
    do_start(0, 16, 4, s);
    push_load(s, 0);
    rd_q.push_back('{s + 10, 6'd16});
    goto(s + 3);
    k_base = 6'd40;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    goto(s + 10);
    reset = 1'b1;
    tick();
    chk("mid_rst_cen", 64'(mem_cen), 64'd0);
    chk("mid_rst_inst", 64'(inst_out), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    goto(s + 20);
    leftovers("abort");

    // Fresh run after the abort completes normally.
    do_start(0, 8, 3, s);
    push_load(s, 0);
    push_exec(s, 8, 3);
    done_q.push_back(s + 19);
    pulse_at(s + 15);
    pulse_at(s + 17);
    pulse_at(s + 18);
    goto(s + 28);
    leftovers("rerun");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
